// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Staged reset release controller. Takes the synchronized reset from the
//   reset synchronizer and stretches it. It then releases the memory,
//   register-file and core resets in that order, with a programmable gap
//   between each release. A software request re-runs the sequence, and so
//   does a watchdog timeout when the watchdog is compiled in. RST_CAUSE
//   records which event caused the most recent reset.
//
//   Build option: define WATCHDOG_EN to include the RUN-state watchdog.
//   Without it, WDT_KICK and WDT_CYCLES have no effect and RST_CAUSE is
//   never 2'b10.

module reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int WDT_CYCLES  = 1024
) (
  input  logic       CLOCK,
  input  logic       RESET_IN,
  input  logic       SW_RST_REQ,
  input  logic       WDT_KICK,
  output logic       MEM_RST_N,
  output logic       RF_RST_N,
  output logic       CORE_RST_N,
  output logic       RST_DONE,
  output logic [1:0] RST_CAUSE
);

  // The shared counter only has to reach the longest terminal count in use.
  localparam int SEQ_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
`ifdef WATCHDOG_EN
  localparam int CNT_MAX = (WDT_CYCLES > SEQ_MAX) ? WDT_CYCLES : SEQ_MAX;
`else
  localparam int CNT_MAX = SEQ_MAX;
`endif
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  localparam logic [1:0] CAUSE_EXT = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
`ifdef WATCHDOG_EN
  localparam logic [1:0]       CAUSE_WDT = 2'b10;
  localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_CYCLES - 1);
`else
  // The kick input and the timeout length exist only for port compatibility.
  logic unused_wdt_kick;
  assign unused_wdt_kick = WDT_KICK;
  localparam int unused_wdt_cycles = WDT_CYCLES;
`endif

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_REL_MEM = 2'd1,
    ST_REL_RF  = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             mem_nx, rf_nx, core_nx, done_nx;
  logic [1:0]       cause_nx;

  // State, counter and all outputs are registered; RESET_IN forces the hold state.
  always_ff @(posedge CLOCK or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state_q    <= ST_HOLD;
      cnt_q      <= CNT_ZERO;
      MEM_RST_N  <= 1'b0;
      RF_RST_N   <= 1'b0;
      CORE_RST_N <= 1'b0;
      RST_DONE   <= 1'b0;
      RST_CAUSE  <= CAUSE_EXT;
    end else begin
      state_q    <= state_nx;
      cnt_q      <= cnt_nx;
      MEM_RST_N  <= mem_nx;
      RF_RST_N   <= rf_nx;
      CORE_RST_N <= core_nx;
      RST_DONE   <= done_nx;
      RST_CAUSE  <= cause_nx;
    end
  end

  // Next-state logic: each state releases at most one stage, so releases are strictly ordered.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    mem_nx   = MEM_RST_N;
    rf_nx    = RF_RST_N;
    core_nx  = CORE_RST_N;
    done_nx  = RST_DONE;
    cause_nx = RST_CAUSE;

    case (state_q)
      ST_HOLD: begin
        mem_nx  = 1'b0;
        rf_nx   = 1'b0;
        core_nx = 1'b0;
        done_nx = 1'b0;
        if (cnt_q == HOLD_LAST) begin
          state_nx = ST_REL_MEM;
          cnt_nx   = CNT_ZERO;
          mem_nx   = 1'b1;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end

      ST_REL_MEM: begin
        if (cnt_q == GAP_LAST) begin
          state_nx = ST_REL_RF;
          cnt_nx   = CNT_ZERO;
          rf_nx    = 1'b1;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end

      ST_REL_RF: begin
        if (cnt_q == GAP_LAST) begin
          state_nx = ST_RUN;
          cnt_nx   = CNT_ZERO;
          core_nx  = 1'b1;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        // A software request takes priority over a watchdog timeout on the same edge.
        if (SW_RST_REQ) begin
          state_nx = ST_HOLD;
          cnt_nx   = CNT_ZERO;
          mem_nx   = 1'b0;
          rf_nx    = 1'b0;
          core_nx  = 1'b0;
          done_nx  = 1'b0;
          cause_nx = CAUSE_SW;
        end
`ifdef WATCHDOG_EN
        // A kick on the timeout edge still saves the system.
        else if (WDT_KICK) begin
          cnt_nx = CNT_ZERO;
        end else if (cnt_q == WDT_LAST) begin
          state_nx = ST_HOLD;
          cnt_nx   = CNT_ZERO;
          mem_nx   = 1'b0;
          rf_nx    = 1'b0;
          core_nx  = 1'b0;
          done_nx  = 1'b0;
          cause_nx = CAUSE_WDT;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_nx = ST_HOLD;
        cnt_nx   = CNT_ZERO;
        mem_nx   = 1'b0;
        rf_nx    = 1'b0;
        core_nx  = 1'b0;
        done_nx  = 1'b0;
      end
    endcase
  end

endmodule
